// File: rtl/readout_sequencer.sv
// Per-shot readout controller: arm -> trigger -> delay -> collect_start -> capture I/Q -> hand off.
// Latency: collect_start rises delay_l+1 cycles after the trigger edge; result registered 1 cycle after iq_valid.
// Backpressure: holds res_valid/res_i/res_q/res_shot until res_ready; no new trigger is taken while draining.
module readout_sequencer #(
    parameter int SHOT_W      = 16,
    parameter int DATA_W      = 32,
    parameter int ACQ_TIMEOUT = 4096
) (
    input  logic              clk100,
    input  logic              reset_n,
    input  logic              arm,
    input  logic              abort,
    input  logic [SHOT_W-1:0] shot_count,
    input  logic [13:0]       delay_time,
    input  logic              trigger,
    input  logic              iq_valid,
    input  logic [DATA_W-1:0] i_val,
    input  logic [DATA_W-1:0] q_val,
    output logic              collect_start,
    output logic              cfg_load_en,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_i,
    output logic [DATA_W-1:0] res_q,
    output logic [SHOT_W-1:0] res_shot,
    output logic              done,
    output logic              timeout_err,
    output logic [7:0]        missed_trig
);

    // Timeout counter only needs to reach ACQ_TIMEOUT-1.
    localparam int TO_W = (ACQ_TIMEOUT > 2) ? $clog2(ACQ_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACQ_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        DELAY   = 3'd2,
        ACQUIRE = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [SHOT_W-1:0] shot_l;
    logic [SHOT_W-1:0] shot_l_nxt;
    logic [13:0]       delay_l;
    logic [13:0]       delay_l_nxt;
    logic [SHOT_W-1:0] shot_idx;
    logic [SHOT_W-1:0] shot_idx_nxt;
    logic [13:0]       dly_cnt;
    logic [13:0]       dly_cnt_nxt;
    logic [TO_W-1:0]   to_cnt;
    logic [TO_W-1:0]   to_cnt_nxt;
    logic [DATA_W-1:0] res_i_nxt;
    logic [DATA_W-1:0] res_q_nxt;
    logic [SHOT_W-1:0] res_shot_nxt;
    logic              res_valid_nxt;
    logic              collect_nxt;
    logic              done_nxt;
    logic              err_nxt;
    logic [7:0]        miss_nxt;
    logic              in_run_window;

    // Config may only be reloaded while the sequencer sits idle.
    assign cfg_load_en = (state == IDLE);
    assign busy        = ~cfg_load_en;

    // Triggers that arrive after the shot's trigger has been taken are counted, never acted on.
    assign in_run_window = (state == DELAY) || (state == ACQUIRE) || (state == DRAIN);

    // Next-state and next-output logic; abort overrides every other event.
    always_comb begin
        state_nxt     = state;
        shot_l_nxt    = shot_l;
        delay_l_nxt   = delay_l;
        shot_idx_nxt  = shot_idx;
        dly_cnt_nxt   = dly_cnt;
        to_cnt_nxt    = to_cnt;
        res_i_nxt     = res_i;
        res_q_nxt     = res_q;
        res_shot_nxt  = res_shot;
        res_valid_nxt = res_valid;
        collect_nxt   = 1'b0;
        done_nxt      = 1'b0;
        err_nxt       = timeout_err;
        miss_nxt      = missed_trig;

        if (abort) begin
            state_nxt     = IDLE;
            res_valid_nxt = 1'b0;
        end else begin
            if (trigger && in_run_window && (missed_trig != 8'hFF)) begin
                miss_nxt = missed_trig + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (arm) begin
                        shot_l_nxt   = shot_count;
                        delay_l_nxt  = delay_time;
                        shot_idx_nxt = '0;
                        err_nxt      = 1'b0;
                        miss_nxt     = 8'd0;
                        if (shot_count == '0) begin
                            done_nxt = 1'b1;
                        end else begin
                            state_nxt = ARMED;
                        end
                    end
                end
                ARMED: begin
                    if (trigger) begin
                        state_nxt   = DELAY;
                        dly_cnt_nxt = 14'd0;
                    end
                end
                DELAY: begin
                    if (dly_cnt == delay_l) begin
                        collect_nxt = 1'b1;
                        to_cnt_nxt  = '0;
                        state_nxt   = ACQUIRE;
                    end else begin
                        dly_cnt_nxt = dly_cnt + 14'd1;
                    end
                end
                ACQUIRE: begin
                    if (iq_valid) begin
                        res_i_nxt     = i_val;
                        res_q_nxt     = q_val;
                        res_shot_nxt  = shot_idx;
                        res_valid_nxt = 1'b1;
                        state_nxt     = DRAIN;
                    end else if (to_cnt == TO_LAST) begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        to_cnt_nxt = to_cnt + TO_W'(1);
                    end
                end
                DRAIN: begin
                    if (res_ready) begin
                        res_valid_nxt = 1'b0;
                        if (shot_idx == (shot_l - SHOT_W'(1))) begin
                            done_nxt  = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            shot_idx_nxt = shot_idx + SHOT_W'(1);
                            state_nxt    = ARMED;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk100) begin
        if (!reset_n) begin
            state         <= IDLE;
            shot_l        <= '0;
            delay_l       <= '0;
            shot_idx      <= '0;
            dly_cnt       <= '0;
            to_cnt        <= '0;
            res_i         <= '0;
            res_q         <= '0;
            res_shot      <= '0;
            res_valid     <= 1'b0;
            collect_start <= 1'b0;
            done          <= 1'b0;
            timeout_err   <= 1'b0;
            missed_trig   <= 8'd0;
        end else begin
            state         <= state_nxt;
            shot_l        <= shot_l_nxt;
            delay_l       <= delay_l_nxt;
            shot_idx      <= shot_idx_nxt;
            dly_cnt       <= dly_cnt_nxt;
            to_cnt        <= to_cnt_nxt;
            res_i         <= res_i_nxt;
            res_q         <= res_q_nxt;
            res_shot      <= res_shot_nxt;
            res_valid     <= res_valid_nxt;
            collect_start <= collect_nxt;
            done          <= done_nxt;
            timeout_err   <= err_nxt;
            missed_trig   <= miss_nxt;
        end
    end

endmodule

// File: tb/tb_readout_sequencer.sv
// Bench for readout_sequencer: directed shots against a time-based reference model.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
// Downstream readiness is driven directly per scenario.
module tb_readout_sequencer;

    localparam int SHOT_W = 16;
    localparam int DATA_W = 32;
    localparam int ACQ    = 16;

    logic              clk100;
    logic              reset_n;
    logic              arm;
    logic              abort;
    logic [SHOT_W-1:0] shot_count;
    logic [13:0]       delay_time;
    logic              trigger;
    logic              iq_valid;
    logic [DATA_W-1:0] i_val;
    logic [DATA_W-1:0] q_val;
    logic              collect_start;
    logic              cfg_load_en;
    logic              busy;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_i;
    logic [DATA_W-1:0] res_q;
    logic [SHOT_W-1:0] res_shot;
    logic              done;
    logic              timeout_err;
    logic [7:0]        missed_trig;

    readout_sequencer #(.SHOT_W(SHOT_W), .DATA_W(DATA_W), .ACQ_TIMEOUT(ACQ)) dut (
        .clk100(clk100), .reset_n(reset_n), .arm(arm), .abort(abort),
        .shot_count(shot_count), .delay_time(delay_time), .trigger(trigger),
        .iq_valid(iq_valid), .i_val(i_val), .q_val(q_val),
        .collect_start(collect_start), .cfg_load_en(cfg_load_en), .busy(busy),
        .res_valid(res_valid), .res_ready(res_ready), .res_i(res_i), .res_q(res_q),
        .res_shot(res_shot), .done(done), .timeout_err(timeout_err),
        .missed_trig(missed_trig)
    );

    initial clk100 = 1'b0;
    always #5 clk100 = ~clk100;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model (event times, not states) ----------------
    int          cyc = 0;
    bit          m_run, m_wait_trig, m_res;
    int          m_fire_at = -1;
    int          m_deadline = -1;
    int          m_shots, m_delay, m_idx;
    bit          e_collect, e_done, e_err;
    int          e_missed;
    logic [31:0] e_res_i, e_res_q;
    int          e_res_shot;

    always @(posedge clk100) begin
        cyc++;
        if (!reset_n) begin
            m_run = 0; m_wait_trig = 0; m_res = 0; m_fire_at = -1; m_deadline = -1;
            m_shots = 0; m_delay = 0; m_idx = 0;
            e_collect = 0; e_done = 0; e_err = 0; e_missed = 0;
            e_res_i = 0; e_res_q = 0; e_res_shot = 0;
        end else begin
            e_collect = 0;
            e_done = 0;
            if (abort) begin
                m_run = 0; m_wait_trig = 0; m_res = 0; m_fire_at = -1; m_deadline = -1;
            end else if (!m_run) begin
                if (arm) begin
                    m_shots = int'(shot_count); m_delay = int'(delay_time);
                    m_idx = 0; e_err = 0; e_missed = 0;
                    if (m_shots == 0) e_done = 1;
                    else begin m_run = 1; m_wait_trig = 1; end
                end
            end else begin
                if (trigger && !m_wait_trig) e_missed = (e_missed < 255) ? e_missed + 1 : 255;
                if (m_wait_trig) begin
                    if (trigger) begin m_wait_trig = 0; m_fire_at = cyc + m_delay + 1; end
                end else if (m_fire_at >= 0) begin
                    if (cyc == m_fire_at) begin e_collect = 1; m_fire_at = -1; m_deadline = cyc + ACQ; end
                end else if (m_deadline >= 0) begin
                    if (iq_valid) begin
                        e_res_i = i_val; e_res_q = q_val; e_res_shot = m_idx;
                        m_res = 1; m_deadline = -1;
                    end else if (cyc == m_deadline) begin
                        e_err = 1; m_run = 0; m_deadline = -1;
                    end
                end else if (m_res && res_ready) begin
                    m_res = 0;
                    if (m_idx == m_shots - 1) begin e_done = 1; m_run = 0; end
                    else begin m_idx++; m_wait_trig = 1; end
                end
            end
        end
    end

    // ---------------- per-cycle compare and event logging ----------------
    int cs_log[$];
    int done_log[$];
    int hs_log[$];
    bit busy_seen;

    always @(negedge clk100) begin
        if (chk_en) begin
            chk("collect_start", collect_start, e_collect);
            chk("cfg_load_en", cfg_load_en, !m_run);
            chk("busy", busy, m_run);
            chk("res_valid", res_valid, m_res);
            chk("done", done, e_done);
            chk("timeout_err", timeout_err, e_err);
            chk("missed_trig", missed_trig, e_missed);
            if (m_res) begin
                chk("res_i", res_i, e_res_i);
                chk("res_q", res_q, e_res_q);
                chk("res_shot", res_shot, e_res_shot);
            end
            if (collect_start) cs_log.push_back(cyc);
            if (done) done_log.push_back(cyc);
            if (res_valid && res_ready) hs_log.push_back(int'(res_shot));
            if (busy) busy_seen = 1'b1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk100);
        #1;
    endtask

    task automatic pulse_arm();
        arm = 1'b1; step(1); arm = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1; step(1); abort = 1'b0;
    endtask

    // Returns the edge number at which the trigger is sampled.
    task automatic pulse_trig(output int t);
        trigger = 1'b1; t = cyc + 1; step(1); trigger = 1'b0;
    endtask

    task automatic send_iq(input logic [31:0] iv, input logic [31:0] qv);
        iq_valid = 1'b1; i_val = iv; q_val = qv; step(1); iq_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    int t, t2, tl[3], c0, d0, h0, ae;

    initial begin
        reset_n = 0; arm = 0; abort = 0; shot_count = 0; delay_time = 0;
        trigger = 0; iq_valid = 0; i_val = 0; q_val = 0; res_ready = 0;
        step(2);
        chk_en = 1'b1;
        // reset values
        chk("rst_cfg_load_en", cfg_load_en, 1);
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_collect", collect_start, 0);
        chk("rst_done", done, 0);
        chk("rst_missed", missed_trig, 0);
        chk("rst_res_i", res_i, 0);
        chk("rst_res_shot", res_shot, 0);
        reset_n = 1;
        step(2);

        // T1: three shots, delay 5, result 10 cycles after collect, ready held high
        shot_count = 3; delay_time = 5; res_ready = 1;
        c0 = cs_log.size(); d0 = done_log.size(); h0 = hs_log.size();
        pulse_arm();
        for (int s = 0; s < 3; s++) begin
            step(2);
            pulse_trig(t);
            tl[s] = t;
            step(15);
            send_iq(32'h100 + s, 32'h200 + s);
            step(3);
        end
        chk("t1_cs_count", cs_log.size() - c0, 3);
        for (int s = 0; s < 3; s++) begin
            chk("t1_cs_time", cs_log[c0 + s], tl[s] + 6);
            chk("t1_res_shot", hs_log[h0 + s], s);
        end
        chk("t1_done_count", done_log.size() - d0, 1);

        // T2: zero delay, then a zero-shot run
        shot_count = 1; delay_time = 0;
        c0 = cs_log.size();
        pulse_arm();
        step(1);
        pulse_trig(t);
        step(2);
        send_iq(32'hA5A5_0001, 32'h5A5A_0002);
        step(3);
        chk("t2_cs_time", cs_log[c0], t + 1);
        shot_count = 0;
        busy_seen = 1'b0;
        d0 = done_log.size();
        ae = cyc + 1;
        pulse_arm();
        step(3);
        chk("t2_busy_seen", busy_seen, 0);
        chk("t2_done_count", done_log.size() - d0, 1);
        chk("t2_done_time", done_log[d0], ae);

        // T3: downstream stalls 50 cycles; stray trigger and arm while draining
        shot_count = 2; delay_time = 1; res_ready = 0;
        d0 = done_log.size();
        pulse_arm();
        step(1);
        pulse_trig(t);
        step(3);
        send_iq(32'hDEAD_BEEF, 32'h1234_5678);
        step(10);
        pulse_trig(t2);
        pulse_arm();
        step(38);
        chk("t3_res_valid", res_valid, 1);
        chk("t3_res_i", res_i, 32'hDEAD_BEEF);
        chk("t3_res_q", res_q, 32'h1234_5678);
        chk("t3_res_shot", res_shot, 0);
        chk("t3_missed", missed_trig, 1);
        res_ready = 1; step(1); res_ready = 0;
        chk("t3_rearmed_busy", busy, 1);
        chk("t3_res_valid_low", res_valid, 0);
        pulse_trig(t);
        step(3);
        send_iq(32'h0BAD_F00D, 32'h0000_0042);
        res_ready = 1; step(2); res_ready = 0;
        chk("t3_last_shot", hs_log[hs_log.size() - 1], 1);
        chk("t3_done_count", done_log.size() - d0, 1);

        // T4: acquisition timeout, then result on the very last permitted cycle
        shot_count = 1; delay_time = 2; res_ready = 1;
        d0 = done_log.size();
        pulse_arm();
        step(1);
        pulse_trig(t);
        step(25);
        chk("t4_timeout_err", timeout_err, 1);
        chk("t4_idle", busy, 0);
        chk("t4_no_done", done_log.size() - d0, 0);
        pulse_arm();
        chk("t4_err_cleared", timeout_err, 0);
        step(1);
        pulse_trig(t);
        step(18);
        send_iq(32'hCAFE_0004, 32'hBEEF_0004);
        chk("t4_late_res_valid", res_valid, 1);
        chk("t4_late_res_i", res_i, 32'hCAFE_0004);
        step(2);
        chk("t4_late_done", done_log.size() - d0, 1);
        chk("t4_late_err", timeout_err, 0);

        // T5: abort in DELAY, ACQUIRE (with iq_valid) and DRAIN; then reset mid-run
        shot_count = 2; delay_time = 10; res_ready = 1;
        d0 = done_log.size();
        pulse_arm();
        step(1);
        pulse_trig(t);
        step(3);
        c0 = cs_log.size();
        pulse_abort();
        chk("t5a_idle", busy, 0);
        step(15);
        chk("t5a_no_cs", cs_log.size() - c0, 0);
        pulse_arm();
        step(1);
        pulse_trig(t);
        step(12);
        iq_valid = 1; i_val = 32'h7777_7777; abort = 1;
        step(1);
        iq_valid = 0; abort = 0;
        chk("t5b_res_valid", res_valid, 0);
        chk("t5b_idle", busy, 0);
        res_ready = 0;
        pulse_arm();
        step(1);
        pulse_trig(t);
        step(12);
        send_iq(32'h1111_2222, 32'h3333_4444);
        pulse_trig(t2);
        step(2);
        chk("t5c_res_valid", res_valid, 1);
        pulse_abort();
        chk("t5c_res_valid_low", res_valid, 0);
        chk("t5c_idle", cfg_load_en, 1);
        chk("t5c_missed_kept", missed_trig, 1);
        chk("t5_no_done", done_log.size() - d0, 0);
        pulse_arm();
        step(1);
        pulse_trig(t);
        pulse_trig(t2);
        reset_n = 0;
        step(1);
        chk("t5d_cfg_load_en", cfg_load_en, 1);
        chk("t5d_busy", busy, 0);
        chk("t5d_missed", missed_trig, 0);
        chk("t5d_collect", collect_start, 0);
        reset_n = 1;
        step(2);

        // T6: config inputs change mid-run; 300 triggers while draining
        shot_count = 2; delay_time = 3; res_ready = 0;
        d0 = done_log.size();
        pulse_arm();
        shot_count = 7; delay_time = 50;
        step(1);
        pulse_trig(t);
        step(5);
        chk("t6_cs_time1", cs_log[cs_log.size() - 1], t + 4);
        send_iq(32'h6666_0000, 32'h6666_0001);
        trigger = 1;
        step(300);
        trigger = 0;
        chk("t6_missed_sat", missed_trig, 255);
        res_ready = 1; step(1); res_ready = 0;
        step(1);
        pulse_trig(t2);
        step(5);
        chk("t6_cs_time2", cs_log[cs_log.size() - 1], t2 + 4);
        send_iq(32'h6666_0002, 32'h6666_0003);
        res_ready = 1; step(2); res_ready = 0;
        chk("t6_done_count", done_log.size() - d0, 1);
        chk("t6_idle", busy, 0);
        step(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
